sram_counter_demo_top: RTL and testbench



---
 rtl/sram_counter_demo_pkg.sv | 39 +++
 rtl/sram_counter_demo_top_lfsr.sv | 35 +++
 rtl/sram_counter_demo_top.sv | 215 +++++++++++++++++++++
 tb/tb_sram_counter_demo_top.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_counter_demo_pkg.sv
// ---------------------------------------------------------------------------
// sram_counter_demo_pkg
// Shared definitions for the external-SRAM self-test demo:
//   - state_t          : sequencer states
//   - LFSR_TAPS        : Galois feedback mask for the 8-bit test pattern
//   - LED_*            : bit positions inside the 16-bit status display
//   - lfsr_next()      : one step of the right-shifting Galois LFSR
// ---------------------------------------------------------------------------
package sram_counter_demo_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CLR,
    W_SETUP,
    W_STROBE,
    W_HOLD,
    W_ADV_H,
    W_ADV_L,
    R_CLR,
    R_WAIT,
    R_ADV_H,
    R_ADV_L,
    DONE
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int LED_DATA_LSB = 0;
  localparam int LED_ERR_LSB  = 8;
  localparam int LED_WRITE    = 12;
  localparam int LED_READ     = 13;
  localparam int LED_PASS     = 14;
  localparam int LED_DONE     = 15;

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/sram_counter_demo_top_lfsr.sv
// ---------------------------------------------------------------------------
// sram_lfsr8
// 8-bit Galois LFSR that produces the SRAM test pattern. The same instance
// generates the words written and, after a reload, the words expected back.
// Ports:
//   clk   in  1  system clock
//   rst   in  1  synchronous active-low reset
//   load  in  1  load seed (zero seed is replaced by 8'h01)
//   step  in  1  advance one LFSR step (ignored while load is high)
//   seed  in  8  seed value
//   value out 8  current pattern word
// ---------------------------------------------------------------------------
module sram_lfsr8
  import sram_counter_demo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  // An all-zero state would lock the LFSR, so a zero seed becomes 8'h01.
  always_ff @(posedge clk) begin
    if (!rst) begin
      value <= 8'h01;
    end else if (load) begin
      value <= (seed == 8'h00) ? 8'h01 : seed;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/sram_counter_demo_top.sv
// ---------------------------------------------------------------------------
// sram_counter_demo_top
// FPGA top level of the external-SRAM self-test. Two 4-bit SRAMs form one
// 8-bit word; their address comes from an external counter driven through
// COUNTER_CLK / COUNTER_RST. INIT writes an LFSR sequence to every address,
// reads it all back, counts mismatches and shows the result on LED_OUT.
// Ports:
//   CLK          in    1   system clock (rising edge)
//   RST          in    1   synchronous active-low reset
//   INIT         in    1   start request, level-sampled in IDLE/DONE
//   SEED         in    8   LFSR seed, captured at start
//   COUNTER_CLK  out   1   external address counter clock
//   COUNTER_RST  out   1   external address counter clear (active-high)
//   WE_BAR       out   1   SRAM write enable (active-low)
//   CHIP1_DATA   inout 4   word bits [3:0]
//   CHIP2_DATA   inout 4   word bits [7:4]
//   LED_OUT      out   16  {done, pass, read, write, errors[3:0], data[7:0]}
// ---------------------------------------------------------------------------
module sram_counter_demo_top
  import sram_counter_demo_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int PHASE_CYCLES = 4
)
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        INIT,
  input  logic [7:0]  SEED,
  output logic        COUNTER_CLK,
  output logic        COUNTER_RST,
  output logic        WE_BAR,
  inout  wire  [3:0]  CHIP1_DATA,
  inout  wire  [3:0]  CHIP2_DATA,
  output logic [15:0] LED_OUT
);

  localparam int PHASE_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [PHASE_W-1:0]   PHASE_LAST = PHASE_W'(PHASE_CYCLES - 1);
  localparam logic [ADDR_BITS-1:0] LAST_INDEX = '1;

  state_t               state;
  logic [PHASE_W-1:0]   phase_cnt;
  logic [ADDR_BITS-1:0] addr_index;
  logic [3:0]           err_count;
  logic [7:0]           read_reg;
  logic [7:0]           seed_reg;
  logic                 drive_en;

  logic                 phase_last;
  logic                 last_word;
  logic                 lfsr_load;
  logic                 lfsr_step;
  logic [7:0]           lfsr_seed;
  logic [7:0]           lfsr_value;
  logic [7:0]           read_word;
  logic                 write_phase;
  logic                 read_phase;
  logic [15:0]          led_next;

  assign phase_last = (phase_cnt == PHASE_LAST);
  assign last_word  = (addr_index == LAST_INDEX);
  assign read_word  = {CHIP2_DATA, CHIP1_DATA};

  // The seed is loaded straight from the port on start, and from the
  // captured copy when the expected sequence is regenerated for read-back.
  assign lfsr_seed = (state == IDLE) ? SEED : seed_reg;
  assign lfsr_load = ((state == IDLE) && INIT) ||
                     ((state == W_ADV_L) && phase_last && last_word);
  assign lfsr_step = phase_last && !last_word &&
                     ((state == W_ADV_L) || (state == R_ADV_L));

  sram_lfsr8 u_lfsr (
    .clk   (CLK),
    .rst   (RST),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (lfsr_seed),
    .value (lfsr_value)
  );

  // The FPGA only owns the buses during the three write-data states.
  assign CHIP1_DATA = drive_en ? lfsr_value[3:0] : 4'bzzzz;
  assign CHIP2_DATA = drive_en ? lfsr_value[7:4] : 4'bzzzz;

  // Sequencer. Pin outputs are set on the transition into the state that
  // owns them, so they line up with the state register and never glitch.
  // WE_BAR falls only after data has been driven for a full phase and rises
  // a full phase before the buses release or the counter clocks.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      addr_index  <= '0;
      err_count   <= 4'h0;
      read_reg    <= 8'h00;
      seed_reg    <= 8'h00;
      drive_en    <= 1'b0;
      COUNTER_CLK <= 1'b0;
      COUNTER_RST <= 1'b1;
      WE_BAR      <= 1'b1;
    end else begin
      if ((state == IDLE) || (state == DONE) || phase_last) begin
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          COUNTER_RST <= 1'b1;
          if (INIT) begin
            seed_reg   <= SEED;
            err_count  <= 4'h0;
            addr_index <= '0;
            state      <= CLR;
          end
        end
        CLR: if (phase_last) begin
          state       <= W_SETUP;
          COUNTER_RST <= 1'b0;
          drive_en    <= 1'b1;
        end
        W_SETUP: if (phase_last) begin
          state  <= W_STROBE;
          WE_BAR <= 1'b0;
        end
        W_STROBE: if (phase_last) begin
          state  <= W_HOLD;
          WE_BAR <= 1'b1;
        end
        W_HOLD: if (phase_last) begin
          state       <= W_ADV_H;
          drive_en    <= 1'b0;
          COUNTER_CLK <= 1'b1;
        end
        W_ADV_H: if (phase_last) begin
          state       <= W_ADV_L;
          COUNTER_CLK <= 1'b0;
        end
        W_ADV_L: if (phase_last) begin
          if (last_word) begin
            addr_index  <= '0;
            state       <= R_CLR;
            COUNTER_RST <= 1'b1;
          end else begin
            addr_index <= addr_index + 1'b1;
            state      <= W_SETUP;
            drive_en   <= 1'b1;
          end
        end
        R_CLR: if (phase_last) begin
          state       <= R_WAIT;
          COUNTER_RST <= 1'b0;
        end
        R_WAIT: if (phase_last) begin
          read_reg <= read_word;
          if ((read_word != lfsr_value) && (err_count != 4'hF)) begin
            err_count <= err_count + 4'h1;
          end
          state       <= R_ADV_H;
          COUNTER_CLK <= 1'b1;
        end
        R_ADV_H: if (phase_last) begin
          state       <= R_ADV_L;
          COUNTER_CLK <= 1'b0;
        end
        R_ADV_L: if (phase_last) begin
          if (last_word) begin
            state <= DONE;
          end else begin
            addr_index <= addr_index + 1'b1;
            state      <= R_WAIT;
          end
        end
        DONE: begin
          if (!INIT) begin
            state       <= IDLE;
            COUNTER_RST <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          drive_en    <= 1'b0;
          WE_BAR      <= 1'b1;
          COUNTER_CLK <= 1'b0;
          COUNTER_RST <= 1'b1;
        end
      endcase
    end
  end

  // Status display contents, derived from the current state and data.
  always_comb begin
    write_phase = (state inside {CLR, W_SETUP, W_STROBE, W_HOLD, W_ADV_H, W_ADV_L});
    read_phase  = (state inside {R_CLR, R_WAIT, R_ADV_H, R_ADV_L});
    led_next    = 16'h0000;
    led_next[LED_DATA_LSB +: 8] = write_phase ? lfsr_value : read_reg;
    led_next[LED_ERR_LSB +: 4]  = err_count;
    led_next[LED_WRITE]         = write_phase;
    led_next[LED_READ]          = read_phase;
    led_next[LED_PASS]          = (state == DONE) && (err_count == 4'h0);
    led_next[LED_DONE]          = (state == DONE);
  end

  // The display is registered, trailing the state it reflects by one cycle.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      LED_OUT <= 16'h0000;
    end else begin
      LED_OUT <= led_next;
    end
  end

endmodule

// File: tb/tb_sram_counter_demo_top.sv
// ---------------------------------------------------------------------------
// tb_sram_counter_demo_top
// Bench for the SRAM self-test top: an external counter plus a 256x8 SRAM
// (with an optional stuck-at-0 mask) surround the design; expected words and
// error counts come from the LFSR rule applied to whole arrays.
// ---------------------------------------------------------------------------
module tb_sram_counter_demo_top;

  logic        clk;
  logic        rst;
  logic        init;
  logic [7:0]  seed;
  logic        counter_clk;
  logic        counter_rst;
  logic        we_bar;
  tri1  [3:0]  chip1_data;
  tri1  [3:0]  chip2_data;
  logic [15:0] led_out;

  int checks;
  int failures;
  int we_pulses;
  int cclk_edges;
  int overlaps;

  logic [7:0] mem [256];
  logic [7:0] exp_words [256];
  logic [7:0] sram_addr;
  logic [7:0] stuck_mask;
  logic [7:0] rd_word;
  logic       sram_oe;

  sram_counter_demo_top #(.ADDR_BITS(8), .PHASE_CYCLES(4)) dut (
    .CLK         (clk),
    .RST         (rst),
    .INIT        (init),
    .SEED        (seed),
    .COUNTER_CLK (counter_clk),
    .COUNTER_RST (counter_rst),
    .WE_BAR      (we_bar),
    .CHIP1_DATA  (chip1_data),
    .CHIP2_DATA  (chip2_data),
    .LED_OUT     (led_out)
  );

  // 100 MHz system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External binary address counter
  always @(posedge counter_clk or posedge counter_rst) begin
    if (counter_rst) sram_addr <= 8'h00;
    else             sram_addr <= sram_addr + 8'h01;
  end

  // SRAM: writes while WE_BAR is low, drives data during the read phase only
  always @(posedge clk) begin
    if (we_bar === 1'b0) mem[sram_addr] <= {chip2_data, chip1_data};
  end

  assign rd_word    = mem[sram_addr] & ~stuck_mask;
  assign sram_oe    = we_bar && led_out[13];
  assign chip1_data = sram_oe ? rd_word[3:0] : 4'bzzzz;
  assign chip2_data = sram_oe ? rd_word[7:4] : 4'bzzzz;

  // Bus activity monitors
  always @(negedge we_bar)      we_pulses++;
  always @(posedge counter_clk) cclk_edges++;
  always @(negedge clk) begin
    if (!we_bar && counter_clk) overlaps++;
  end

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, expv);
    end
  endtask

  // Expected sequence straight from the LFSR rule
  task automatic buildExpected(input logic [7:0] s);
    logic [7:0] x;
    x = (s == 8'h00) ? 8'h01 : s;
    for (int i = 0; i < 256; i++) begin
      exp_words[i] = x;
      x = {1'b0, x[7:1]} ^ (x[0] ? 8'hB8 : 8'h00);
    end
  endtask

  task automatic startRun(input logic [7:0] s, input bit hold);
    buildExpected(s);
    for (int i = 0; i < 256; i++) mem[i] = ~exp_words[i];
    we_pulses  = 0;
    cclk_edges = 0;
    overlaps   = 0;
    @(negedge clk);
    seed = s;
    init = 1'b1;
    if (!hold) begin
      @(negedge clk);
      init = 1'b0;
    end
  endtask

  task automatic waitDone(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 12000; c++) begin
      @(negedge clk);
      if (led_out[15]) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("done_within_budget", {31'd0, ok}, 32'd1);
  endtask

  task automatic applyStimulus(input logic [7:0] s, input bit hold);
    bit ok;
    startRun(s, hold);
    waitDone(ok);
  endtask

  task automatic verifyRun(input string name, input bit hold);
    int bad;
    int errs;
    bad  = 0;
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] !== exp_words[i]) bad++;
      if ((exp_words[i] & ~stuck_mask) != exp_words[i]) errs++;
    end
    if (errs > 15) errs = 15;
    checkOutput({name, "_mem_mismatches"}, bad, 0);
    checkOutput({name, "_we_pulses"}, we_pulses, 256);
    checkOutput({name, "_counter_edges"}, cclk_edges, 512);
    checkOutput({name, "_we_clk_overlap"}, overlaps, 0);
    checkOutput({name, "_led_done"}, led_out[15], 1);
    checkOutput({name, "_led_pass"}, led_out[14], (errs == 0) ? 1 : 0);
    checkOutput({name, "_led_errors"}, led_out[11:8], errs);
    checkOutput({name, "_led_phase"}, led_out[13:12], 0);
    checkOutput({name, "_led_last_read"}, led_out[7:0], exp_words[255] & ~stuck_mask);
    if (hold) begin
      repeat (40) @(negedge clk);
      checkOutput({name, "_hold_stays_done"}, led_out[15], 1);
      checkOutput({name, "_hold_no_repeat"}, we_pulses, 256);
      init = 1'b0;
    end
    repeat (3) @(negedge clk);
    checkOutput({name, "_back_idle_done"}, led_out[15], 0);
    checkOutput({name, "_back_idle_crst"}, counter_rst, 1);
  endtask

  initial begin
    int n;
    int pulses_at_reset;
    bit found;
    logic [7:0] rseed;

    checks     = 0;
    failures   = 0;
    we_pulses  = 0;
    cclk_edges = 0;
    overlaps   = 0;
    stuck_mask = 8'h00;
    rst  = 1'b0;
    init = 1'b0;
    seed = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_we_bar", we_bar, 1);
    checkOutput("reset_counter_rst", counter_rst, 1);
    checkOutput("reset_counter_clk", counter_clk, 0);
    checkOutput("reset_led", led_out, 16'h0000);
    checkOutput("reset_bus_released", {chip2_data, chip1_data}, 8'hFF);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Good SRAM, seed 23
    applyStimulus(8'd23, 1'b0);
    checkOutput("seed23_word0", mem[0], 8'h17);
    checkOutput("seed23_word1", mem[1], 8'hB3);
    verifyRun("seed23", 1'b0);

    // Bit 5 stuck at 0: error count saturates
    stuck_mask = 8'h20;
    applyStimulus(8'd23, 1'b0);
    verifyRun("stuck5", 1'b0);
    checkOutput("stuck5_saturated", led_out[11:8], 4'hF);
    stuck_mask = 8'h00;

    // Zero seed is replaced by 8'h01
    applyStimulus(8'd0, 1'b0);
    checkOutput("seed0_word0", mem[0], 8'h01);
    checkOutput("seed0_word1", mem[1], 8'hB8);
    verifyRun("seed0", 1'b0);

    // Random seed with INIT held high: no auto-repeat
    rseed = 8'($urandom_range(255));
    applyStimulus(rseed, 1'b1);
    verifyRun("rand_hold", 1'b1);

    // Reset during a write strobe at a random point
    rseed = 8'($urandom_range(255));
    n = $urandom_range(1, 20);
    startRun(rseed, 1'b0);
    for (int c = 0; c < 3000 && we_pulses < n; c++) @(negedge clk);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (we_bar === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("midreset_found_strobe", {31'd0, found}, 32'd1);
    rst = 1'b0;
    pulses_at_reset = we_pulses;
    @(posedge clk);
    #1;
    checkOutput("midreset_we_bar", we_bar, 1);
    checkOutput("midreset_bus_released", {chip2_data, chip1_data}, 8'hFF);
    checkOutput("midreset_counter_rst", counter_rst, 1);
    checkOutput("midreset_led", led_out, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("midreset_stays_idle_we", we_pulses, pulses_at_reset);
    checkOutput("midreset_stays_idle_crst", counter_rst, 1);
    checkOutput("midreset_stays_idle_led", led_out, 16'h0000);

    // Restart after the aborted run
    rseed = 8'($urandom_range(255));
    applyStimulus(rseed, 1'b0);
    verifyRun("restart", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
